cpu_writeback_checker: RTL and testbench
========================================

Name: cpu_writeback_checker

Overview:
- Synthesizable, parametrised in-system checker for the CPU core.
- Monitors the register-file write port and PC, and compares every register write against a queue of expected (register, value) entries loaded beforehand or streamed in.
- Detects program halt (PC stuck) or timeout, and reports pass/fail, error count, cycle and write counts, and the first mismatch.
- Sits beside the CPU in sim and FPGA builds; replaces hand-written per-instruction bench checks.

Parameters:
- DATA_W, 8, register/write-data width
- PC_W, 4, program counter width
- RADDR_W, 2, register address width
- DEPTH, 16, expected-entry FIFO depth (power of two, ≥2)
- HALT_CYCLES, 3, consecutive cycles with unchanged PC that signal halt (≥2)
- TIMEOUT, 500, RUN cycles before forced finish
- CNT_W, 32, cycle/write counter width

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; clears result state and enters RUN
- exp_valid  in  1  expected entry offered
- exp_ready  out  1  FIFO can accept an entry
- exp_addr  in  RADDR_W  expected destination register
- exp_data  in  DATA_W  expected written value
- mon_pc  in  PC_W  CPU program counter
- mon_we  in  1  CPU register write enable
- mon_waddr  in  RADDR_W  CPU write address
- mon_wdata  in  DATA_W  CPU write data
- busy  out  1  state is RUN
- done  out  1  state is DONE
- pass  out  1  valid when done
- timeout  out  1  finish was caused by TIMEOUT
- err_count  out  8  mismatches plus unexpected writes, saturating at 255
- cycle_count  out  CNT_W  RUN cycles elapsed
- write_count  out  CNT_W  monitored writes in RUN
- fail_idx  out  CNT_W  write_count value of the first error
- fail_data  out  DATA_W  mon_wdata of the first error

Behaviour:
- Reset: state IDLE; FIFO empty. All outputs 0 except exp_ready=1.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start. DONE→RUN on start.
  - RUN→DONE on halt or timeout.
  - start during RUN is ignored.
- On start: clear cycle_count, write_count, err_count, fail_idx, fail_data, timeout, halt counter. Capture pc_q=mon_pc. The FIFO is not cleared.
- FIFO push:
  - exp_ready = !full, in every state.
  - Push when exp_valid && exp_ready.
  - When full, a same-cycle pop does not raise exp_ready; it updates the next cycle.
  - Push and pop in one cycle keeps occupancy unchanged.
- RUN, each cycle:
  - cycle_count++.
  - pc_q<=mon_pc.
  - stable counter increments if mon_pc==pc_q, else clears to 0.
- RUN write, when mon_we=1:
  - write_count++.
  - If FIFO not empty: pop the head. A mismatch on addr or data is an error.
  - If FIFO empty: the write is an unexpected-write error; nothing is popped.
- On any error: err_count++ (saturating). If it is the first error, latch fail_idx = write_count before increment, and fail_data = mon_wdata.
- Writes outside RUN are ignored entirely; nothing is popped.
- Halt: when the stable counter reaches HALT_CYCLES-1, go to DONE next cycle. A write in that same cycle is still checked.
- Timeout: when cycle_count reaches TIMEOUT-1 in RUN, go to DONE with timeout=1.
- If halt and timeout fire in the same cycle, halt wins and timeout=0.
- DONE:
  - pass = (err_count==0) && FIFO empty && !timeout.
  - Leftover entries (missing writes) force pass=0 but do not add to err_count.
  - All results hold until start or reset.
- Reset mid-RUN: immediate return to the reset state; FIFO entries are discarded.

Optional Feature:
- Macro CHK_PCSTAMP_EN.
- Defined:
  - Adds input exp_pc[PC_W-1:0]; each FIFO entry stores it.
  - On a monitored write, mon_pc != stored PC also counts as a mismatch.
  - Adds output fail_pc[PC_W-1:0], latched with mon_pc at the first error and reset to 0.
- Undefined: no exp_pc/fail_pc ports; PC is used only for halt detection.

Test Plan:
- Preload 11 entries (0,02)(1,03)(2,00)(3,01)(2,02)(2,06)(0,02)(0,03)(1,00)(3,FE)(0,03); start; drive the matching write sequence; hold mon_pc=3 → done=1, pass=1, err_count=0, write_count=11.
- Same, but the 6th write has data 0x05 instead of 0x06 → pass=0, err_count=1, fail_idx=5, fail_data=0x05.
- Preload 3 entries, drive 4 writes → err_count=1 (unexpected write), fail_idx=3, pass=0.
- Push 16 entries with no start → exp_ready=0 after the 16th; a 17th exp_valid is not accepted; start plus one write → exp_ready=1 the next cycle.
- TIMEOUT=20, PC toggles every cycle → done at cycle_count=20, timeout=1, pass=0; rerun with PC stuck from cycle 19 → halt wins, timeout=0.
- Assert reset for 1 cycle mid-RUN after 5 writes → all counters 0, state IDLE, FIFO empty, exp_ready=1.

Source files
------------

// File: rtl/cpu_writeback_checker.sv
// In-system writeback checker: compares CPU register writes against a FIFO of expected
// entries, detects halt (stable PC) or timeout. Optional macro CHK_PCSTAMP_EN adds PC stamping.
module cpu_writeback_checker #(
    parameter int DATA_W      = 8,
    parameter int PC_W        = 4,
    parameter int RADDR_W     = 2,
    parameter int DEPTH       = 16,
    parameter int HALT_CYCLES = 3,
    parameter int TIMEOUT     = 500,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               exp_valid,
    output logic               exp_ready,
    input  logic [RADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0]  exp_data,
    input  logic [PC_W-1:0]    mon_pc,
    input  logic               mon_we,
    input  logic [RADDR_W-1:0] mon_waddr,
    input  logic [DATA_W-1:0]  mon_wdata,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [7:0]         err_count,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   write_count,
    output logic [CNT_W-1:0]   fail_idx,
    output logic [DATA_W-1:0]  fail_data
`ifdef CHK_PCSTAMP_EN
    ,
    input  logic [PC_W-1:0]    exp_pc,
    output logic [PC_W-1:0]    fail_pc
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int STB_W = $clog2(HALT_CYCLES + 1);

    localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);
    localparam logic [PTR_W:0]   ZERO_CNT  = {(PTR_W + 1){1'b0}};
    localparam logic [PTR_W:0]   ONE_CNT   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(DEPTH);
    localparam logic [STB_W-1:0] ZERO_STB  = {STB_W{1'b0}};
    localparam logic [STB_W-1:0] ONE_STB   = STB_W'(1);
    localparam logic [STB_W-1:0] HALT_LAST = STB_W'(HALT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ZERO_CYC  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_CYC   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r;
    logic [RADDR_W-1:0]   fifo_addr_r [DEPTH];
    logic [DATA_W-1:0]    fifo_data_r [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [PTR_W:0]       count_r;
    logic                 exp_ready_r;
    logic [PC_W-1:0]      pc_q_r;
    logic [STB_W-1:0]     stable_r;
    logic [CNT_W-1:0]     cycle_count_r;
    logic [CNT_W-1:0]     write_count_r;
    logic [7:0]           err_count_r;
    logic [CNT_W-1:0]     fail_idx_r;
    logic [DATA_W-1:0]    fail_data_r;
    logic                 timeout_r;
    logic                 pass_r;
`ifdef CHK_PCSTAMP_EN
    logic [PC_W-1:0]      fifo_pc_r [DEPTH];
    logic [PC_W-1:0]      fail_pc_r;
`endif

    logic                 push_s;
    logic                 write_act_s;
    logic                 fifo_empty_s;
    logic                 pop_s;
    logic                 mismatch_s;
    logic                 err_ev_s;
    logic                 first_err_s;
    logic                 halt_s;
    logic                 tmo_s;
    logic [PTR_W:0]       count_next_s;
    logic [STB_W-1:0]     stable_next_s;
    logic [7:0]           err_count_next_s;

    // Next-state decode for FIFO occupancy, write checking, halt and timeout detection.
    always_comb begin
        push_s       = exp_valid && exp_ready_r;
        write_act_s  = (state_r == ST_RUN) && mon_we;
        fifo_empty_s = (count_r == ZERO_CNT);
        pop_s        = write_act_s && !fifo_empty_s;
`ifdef CHK_PCSTAMP_EN
        mismatch_s   = (fifo_addr_r[rd_ptr_r] != mon_waddr) ||
                       (fifo_data_r[rd_ptr_r] != mon_wdata) ||
                       (fifo_pc_r[rd_ptr_r] != mon_pc);
`else
        mismatch_s   = (fifo_addr_r[rd_ptr_r] != mon_waddr) ||
                       (fifo_data_r[rd_ptr_r] != mon_wdata);
`endif
        // An empty FIFO at write time means the CPU wrote something nobody expected.
        err_ev_s     = write_act_s && (fifo_empty_s || mismatch_s);
        first_err_s  = err_ev_s && (err_count_r == 8'd0);

        if (push_s && !pop_s) begin
            count_next_s = count_r + ONE_CNT;
        end else if (!push_s && pop_s) begin
            count_next_s = count_r - ONE_CNT;
        end else begin
            count_next_s = count_r;
        end

        if (mon_pc != pc_q_r) begin
            stable_next_s = ZERO_STB;
        end else if (stable_r != HALT_LAST) begin
            stable_next_s = stable_r + ONE_STB;
        end else begin
            stable_next_s = stable_r;
        end

        if (err_ev_s && (err_count_r != 8'hFF)) begin
            err_count_next_s = err_count_r + 8'd1;
        end else begin
            err_count_next_s = err_count_r;
        end

        halt_s = (state_r == ST_RUN) && (stable_r == HALT_LAST);
        tmo_s  = (state_r == ST_RUN) && (cycle_count_r == TMO_LAST) && !halt_s;
    end

    // Expected-entry storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= exp_addr;
            fifo_data_r[wr_ptr_r] <= exp_data;
`ifdef CHK_PCSTAMP_EN
            fifo_pc_r[wr_ptr_r]   <= exp_pc;
`endif
        end
    end

    // Control FSM, FIFO pointers and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= ZERO_CNT;
            exp_ready_r   <= 1'b1;
            pc_q_r        <= {PC_W{1'b0}};
            stable_r      <= ZERO_STB;
            cycle_count_r <= ZERO_CYC;
            write_count_r <= ZERO_CYC;
            err_count_r   <= 8'd0;
            fail_idx_r    <= ZERO_CYC;
            fail_data_r   <= {DATA_W{1'b0}};
            timeout_r     <= 1'b0;
            pass_r        <= 1'b0;
`ifdef CHK_PCSTAMP_EN
            fail_pc_r     <= {PC_W{1'b0}};
`endif
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end
            count_r     <= count_next_s;
            exp_ready_r <= (count_next_s != FULL_CNT);

            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // Results persist here until a new start; the FIFO is deliberately kept.
                    if (start) begin
                        state_r       <= ST_RUN;
                        pc_q_r        <= mon_pc;
                        stable_r      <= ZERO_STB;
                        cycle_count_r <= ZERO_CYC;
                        write_count_r <= ZERO_CYC;
                        err_count_r   <= 8'd0;
                        fail_idx_r    <= ZERO_CYC;
                        fail_data_r   <= {DATA_W{1'b0}};
                        timeout_r     <= 1'b0;
                        pass_r        <= 1'b0;
`ifdef CHK_PCSTAMP_EN
                        fail_pc_r     <= {PC_W{1'b0}};
`endif
                    end
                end
                ST_RUN: begin
                    cycle_count_r <= cycle_count_r + ONE_CYC;
                    pc_q_r        <= mon_pc;
                    stable_r      <= stable_next_s;
                    err_count_r   <= err_count_next_s;
                    if (write_act_s) begin
                        write_count_r <= write_count_r + ONE_CYC;
                    end
                    if (first_err_s) begin
                        fail_idx_r  <= write_count_r;
                        fail_data_r <= mon_wdata;
`ifdef CHK_PCSTAMP_EN
                        fail_pc_r   <= mon_pc;
`endif
                    end
                    if (halt_s) begin
                        state_r <= ST_DONE;
                        pass_r  <= (err_count_next_s == 8'd0) && (count_next_s == ZERO_CNT);
                    end else if (tmo_s) begin
                        state_r   <= ST_DONE;
                        timeout_r <= 1'b1;
                        pass_r    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign exp_ready   = exp_ready_r;
    assign busy        = (state_r == ST_RUN);
    assign done        = (state_r == ST_DONE);
    assign pass        = pass_r;
    assign timeout     = timeout_r;
    assign err_count   = err_count_r;
    assign cycle_count = cycle_count_r;
    assign write_count = write_count_r;
    assign fail_idx    = fail_idx_r;
    assign fail_data   = fail_data_r;
`ifdef CHK_PCSTAMP_EN
    assign fail_pc     = fail_pc_r;
`endif

endmodule

// File: tb/tb_cpu_writeback_checker.sv
// Bench for cpu_writeback_checker: directed scenarios plus randomized runs, checked against
// a queue-based reference model of the checking rules.
module tb_cpu_writeback_checker;

    localparam int DATA_W      = 8;
    localparam int PC_W        = 4;
    localparam int RADDR_W     = 2;
    localparam int DEPTH       = 16;
    localparam int HALT_CYCLES = 3;
    localparam int TIMEOUT     = 20;
    localparam int CNT_W       = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               exp_valid;
    logic               exp_ready;
    logic [RADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0]  exp_data;
    logic [PC_W-1:0]    mon_pc;
    logic               mon_we;
    logic [RADDR_W-1:0] mon_waddr;
    logic [DATA_W-1:0]  mon_wdata;
    logic               busy;
    logic               done;
    logic               pass;
    logic               timeout;
    logic [7:0]         err_count;
    logic [CNT_W-1:0]   cycle_count;
    logic [CNT_W-1:0]   write_count;
    logic [CNT_W-1:0]   fail_idx;
    logic [DATA_W-1:0]  fail_data;
`ifdef CHK_PCSTAMP_EN
    logic [PC_W-1:0]    exp_pc_tb = 4'd0;
    logic [PC_W-1:0]    fail_pc;
`endif

    cpu_writeback_checker #(
        .DATA_W(DATA_W), .PC_W(PC_W), .RADDR_W(RADDR_W), .DEPTH(DEPTH),
        .HALT_CYCLES(HALT_CYCLES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_addr(exp_addr), .exp_data(exp_data),
        .mon_pc(mon_pc), .mon_we(mon_we), .mon_waddr(mon_waddr), .mon_wdata(mon_wdata),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
        .cycle_count(cycle_count), .write_count(write_count),
        .fail_idx(fail_idx), .fail_data(fail_data)
`ifdef CHK_PCSTAMP_EN
        , .exp_pc(exp_pc_tb), .fail_pc(fail_pc)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [RADDR_W-1:0] a;
        logic [DATA_W-1:0]  d;
    } ent_t;

    // Reference model state: 0 idle, 1 run, 2 done.
    ent_t q[$];
    int   m_state  = 0;
    int   m_cycle  = 0;
    int   m_writes = 0;
    int   m_err    = 0;
    int   m_fidx   = 0;
    int   m_fdata  = 0;
    int   m_stable = 0;
    bit   m_tmo    = 1'b0;
    bit   m_pass   = 1'b0;
    bit   m_ready  = 1'b1;
    logic [PC_W-1:0] m_pcq = 4'd0;

    logic [RADDR_W-1:0] t_a [11];
    logic [DATA_W-1:0]  t_d [11];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Apply the checking rules to the inputs presented in the current cycle.
    task automatic model_step();
        bit   push_m;
        bit   bad;
        bit   halt_m;
        bit   tmo_m;
        ent_t head;
        push_m = exp_valid && m_ready;
        if (reset) begin
            q.delete();
            m_state = 0; m_cycle = 0; m_writes = 0; m_err = 0; m_fidx = 0; m_fdata = 0;
            m_stable = 0; m_tmo = 1'b0; m_pass = 1'b0; m_ready = 1'b1; m_pcq = 4'd0;
        end else begin
            if (m_state == 1 && mon_we) begin
                bad = 1'b1;
                if (q.size() > 0) begin
                    head = q.pop_front();
                    bad  = (head.a != mon_waddr) || (head.d != mon_wdata);
                end
                if (bad) begin
                    if (m_err == 0) begin
                        m_fidx  = m_writes;
                        m_fdata = int'(mon_wdata);
                    end
                    if (m_err < 255) m_err++;
                end
                m_writes++;
            end
            if (push_m) q.push_back({exp_addr, exp_data});
            if (m_state == 1) begin
                halt_m   = (m_stable == HALT_CYCLES - 1);
                tmo_m    = (m_cycle == TIMEOUT - 1);
                m_stable = (mon_pc == m_pcq) ? m_stable + 1 : 0;
                m_pcq    = mon_pc;
                m_cycle++;
                if (halt_m) begin
                    m_state = 2;
                    m_pass  = (m_err == 0) && (q.size() == 0);
                end else if (tmo_m) begin
                    m_state = 2;
                    m_tmo   = 1'b1;
                    m_pass  = 1'b0;
                end
            end else if (start) begin
                m_state = 1; m_cycle = 0; m_writes = 0; m_err = 0; m_fidx = 0; m_fdata = 0;
                m_stable = 0; m_tmo = 1'b0; m_pass = 1'b0; m_pcq = mon_pc;
            end
            m_ready = (q.size() < DEPTH);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("busy",        64'(busy),        64'(m_state == 1));
        chk("done",        64'(done),        64'(m_state == 2));
        chk("pass",        64'(pass),        64'(m_pass));
        chk("timeout",     64'(timeout),     64'(m_tmo));
        chk("err_count",   64'(err_count),   64'(m_err));
        chk("cycle_count", 64'(cycle_count), 64'(m_cycle));
        chk("write_count", 64'(write_count), 64'(m_writes));
        chk("fail_idx",    64'(fail_idx),    64'(m_fidx));
        chk("fail_data",   64'(fail_data),   64'(m_fdata));
        chk("exp_ready",   64'(exp_ready),   64'(m_ready));
    endtask

    task automatic push_entry(input logic [RADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_valid = 1'b1; exp_addr = a; exp_data = d;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic do_start(input logic [PC_W-1:0] pc);
        start = 1'b1; mon_pc = pc;
        tick();
        start = 1'b0;
    endtask

    task automatic wr(input logic [RADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [PC_W-1:0] pc);
        mon_we = 1'b1; mon_waddr = a; mon_wdata = d; mon_pc = pc;
        tick();
        mon_we = 1'b0;
    endtask

    task automatic run_to_done(input logic [PC_W-1:0] pc);
        mon_pc = pc;
        for (int i = 0; i < 40; i++) begin
            if (m_state != 2) tick();
        end
        chk("reach_done", 64'(done), 64'(1));
    endtask

    initial begin
        t_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd3, 2'd0};
        t_d = '{8'h02, 8'h03, 8'h00, 8'h01, 8'h02, 8'h06, 8'h02, 8'h03, 8'h00, 8'hFE, 8'h03};
        reset = 1'b1; start = 1'b0; exp_valid = 1'b0; exp_addr = 2'd0; exp_data = 8'd0;
        mon_pc = 4'd0; mon_we = 1'b0; mon_waddr = 2'd0; mon_wdata = 8'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_ready", 64'(exp_ready), 64'(1));

        // Full matching program.
        for (int i = 0; i < 11; i++) push_entry(t_a[i], t_d[i]);
        do_start(4'd0);
        for (int i = 0; i < 11; i++) wr(t_a[i], t_d[i], 4'(4 + i));
        run_to_done(4'd3);
        chk("t1_pass", 64'(pass), 64'(1));
        chk("t1_err", 64'(err_count), 64'(0));
        chk("t1_writes", 64'(write_count), 64'(11));

        // Sixth write carries wrong data.
        for (int i = 0; i < 11; i++) push_entry(t_a[i], t_d[i]);
        do_start(4'd0);
        for (int i = 0; i < 11; i++) wr(t_a[i], (i == 5) ? 8'h05 : t_d[i], 4'(4 + i));
        run_to_done(4'd3);
        chk("t2_pass", 64'(pass), 64'(0));
        chk("t2_err", 64'(err_count), 64'(1));
        chk("t2_fail_idx", 64'(fail_idx), 64'(5));
        chk("t2_fail_data", 64'(fail_data), 64'(8'h05));

        // One write more than expected.
        for (int i = 0; i < 3; i++) push_entry(t_a[i], t_d[i]);
        do_start(4'd0);
        for (int i = 0; i < 3; i++) wr(t_a[i], t_d[i], 4'(4 + i));
        wr(2'd1, 8'hAA, 4'd9);
        run_to_done(4'd3);
        chk("t3_err", 64'(err_count), 64'(1));
        chk("t3_fail_idx", 64'(fail_idx), 64'(3));
        chk("t3_pass", 64'(pass), 64'(0));

        // PC toggles forever: timeout.
        do_start(4'd0);
        for (int k = 0; k < 30; k++) begin
            mon_pc = (k % 2 == 1) ? 4'd1 : 4'd2;
            if (m_state != 2) tick();
        end
        chk("tmo_cycles", 64'(cycle_count), 64'(20));
        chk("tmo_flag", 64'(timeout), 64'(1));
        chk("tmo_pass", 64'(pass), 64'(0));

        // PC becomes stuck so halt and timeout coincide: halt wins.
        do_start(4'd7);
        for (int k = 0; k < 30; k++) begin
            mon_pc = (k < 17 && (k % 2 == 1)) ? 4'd5 : 4'd6;
            if (m_state != 2) tick();
        end
        chk("hw_done", 64'(done), 64'(1));
        chk("hw_timeout", 64'(timeout), 64'(0));
        chk("hw_cycles", 64'(cycle_count), 64'(20));

        // Randomized runs against the model.
        for (int it = 0; it < 6; it++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) push_entry(2'($urandom), 8'($urandom));
            do_start(4'd0);
            for (int k = 0; k < 8; k++) begin
                mon_pc    = 4'(k + 1);
                mon_we    = 1'($urandom_range(0, 1));
                exp_valid = ($urandom_range(0, 4) == 0);
                exp_addr  = 2'($urandom);
                exp_data  = 8'($urandom);
                if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    mon_waddr = q[0].a;
                    mon_wdata = q[0].d;
                end else begin
                    mon_waddr = 2'($urandom);
                    mon_wdata = 8'($urandom);
                end
                tick();
            end
            mon_we = 1'b0; exp_valid = 1'b0;
            run_to_done(4'd3);
        end

        // Fill the FIFO with no run active.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) push_entry(2'($urandom), 8'($urandom));
        chk("full_ready", 64'(exp_ready), 64'(0));
        push_entry(2'd3, 8'h77);
        chk("full_ready_17", 64'(exp_ready), 64'(0));
        do_start(4'd0);
        wr(q[0].a, q[0].d, 4'd1);
        chk("pop_ready", 64'(exp_ready), 64'(1));
        for (int i = 0; i < 4; i++) wr(q[0].a, q[0].d, 4'(2 + i));
        chk("mid_writes", 64'(write_count), 64'(5));

        // Reset mid-run discards everything.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_ready", 64'(exp_ready), 64'(1));
        chk("rst_writes", 64'(write_count), 64'(0));
        do_start(4'd0);
        wr(2'd0, 8'h11, 4'd1);
        chk("rst_fifo_empty_err", 64'(err_count), 64'(1));
        run_to_done(4'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
